// File: rtl/screen_sequencer.sv
// Game-screen FSM and final pixel mux/register feeding the VGA DAC.
// Optional build macro WIN_FADE_EN adds a 16-frame fade-in on the winner screens.
module screen_sequencer #(
    parameter int WIN_FRAMES = 180,
    parameter int CNT_W      = 8,
    parameter bit VS_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        vsync,
    input  logic        start_btn,
    input  logic        p1_dead,
    input  logic        p2_dead,
    input  logic [11:0] title_px,
    input  logic [11:0] game_px,
    input  logic [11:0] win_out1,
    input  logic [11:0] win_out2,
    output logic [11:0] rgb,
    output logic [2:0]  scr_state,
    output logic        game_active
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_WIN1  = 3'd2,
        S_WIN2  = 3'd3,
        S_DRAW  = 3'd4
    } scr_e;

    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(WIN_FRAMES - 1);

    scr_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             vs_q;
    logic             armed_q;
    logic             ga_q;
    logic [11:0]      rgb_q, rgb_d;

    logic             vs_act;
    logic             tick;
    logic             start_now;
    logic             p1_now;
    logic             p2_now;
    logic [11:0]      src;

    assign vs_act = VS_ACT_LOW ? ~vsync : vsync;
    // armed_q suppresses a tick on the first clk out of reset
    assign tick   = armed_q & vs_act & ~vs_q;

    assign start_now = start_q | ((state_q == S_TITLE) & start_btn);
    assign p1_now    = p1_q | ((state_q == S_PLAY) & p1_dead);
    assign p2_now    = p2_q | ((state_q == S_PLAY) & p2_dead);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_now;
        p1_d    = p1_now;
        p2_d    = p2_now;
        if (tick) begin
            start_d = 1'b0;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
        end
        case (state_q)
            S_TITLE: begin
                if (tick && start_now) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (p1_now && p2_now) begin
                        state_d = S_DRAW;
                    end else if (p2_now) begin
                        state_d = S_WIN1;
                    end else if (p1_now) begin
                        state_d = S_WIN2;
                    end
                end
            end
            S_WIN1, S_WIN2, S_DRAW: begin
                if (tick) begin
                    if (cnt_q == LAST_FRAME) begin
                        state_d = S_TITLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_TITLE;
                start_d = 1'b0;
                p1_d    = 1'b0;
                p2_d    = 1'b0;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

`ifdef WIN_FADE_EN
    logic [1:0] fade_sh;

    always_comb begin
        fade_sh = 2'd0;
        if (cnt_q < CNT_W'(16)) begin
            fade_sh = 2'd3 - cnt_q[3:2];
        end
    end

    function automatic logic [11:0] fade(input logic [11:0] c,
                                         input logic [1:0]  s);
        logic [3:0] r, g, b;
        r = c[11:8] >> s;
        g = c[7:4] >> s;
        b = c[3:0] >> s;
        return {r, g, b};
    endfunction
`endif

    always_comb begin
        src = 12'h000;
        case (state_q)
            S_TITLE: src = title_px;
            S_PLAY:  src = game_px;
`ifdef WIN_FADE_EN
            S_WIN1:  src = fade(win_out1, fade_sh);
            S_WIN2:  src = fade(win_out2, fade_sh);
`else
            S_WIN1:  src = win_out1;
            S_WIN2:  src = win_out2;
`endif
            S_DRAW:  src = title_px;
            default: src = 12'h000;
        endcase
        rgb_d = video_on ? src : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_TITLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            vs_q    <= 1'b0;
            armed_q <= 1'b0;
            ga_q    <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            vs_q    <= vs_act;
            armed_q <= 1'b1;
            ga_q    <= (state_d == S_PLAY);
            rgb_q   <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign scr_state   = state_q;
    assign game_active = ga_q;

endmodule
